// File: rtl/trig_adc_averager.sv
// trig_adc_averager
// Trigger-synchronous ADC window averager. A trigger edge (rising, or
// rising/falling in differential mode) starts a measurement: wait OFFSET
// cycles for settling, sum 2^LOG2_N consecutive samples, and store the
// truncated mean as J_POS (rising) or J_NEG (falling). In differential
// mode a falling measurement that follows a rising one also produces
// DJ = J_POS - J_NEG.
//
// Ports
//   adc_clk  in   sole clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   trig_in  in   asynchronous trigger square wave
//   adc_in   in   ADC sample (unsigned), synchronous to adc_clk
//   en       in   enable; low aborts to IDLE and clears overrun/pairing
//   mode     in   0 = rising edges only, 1 = rising and falling edges
//   offset   in   settling delay in adc_clk cycles
//   j_pos    out  mean of last rising-edge window
//   j_neg    out  mean of last falling-edge window
//   dj       out  signed j_pos - j_neg
//   valid    out  one-cycle result strobe
//   busy     out  measurement in progress
//   overrun  out  sticky: trigger edge seen while busy
//
// State table
//   S_IDLE  | waiting for a qualifying trigger edge
//   S_DELAY | settling countdown after the trigger
//   S_ACCUM | summing the sample window
//   S_DONE  | storing the window mean
module trig_adc_averager #(
  parameter int ADC_W    = 12,
  parameter int LOG2_N   = 4,
  parameter int OFFSET_W = 16
) (
  input  logic                adc_clk,
  input  logic                rst_n,
  input  logic                trig_in,
  input  logic [ADC_W-1:0]    adc_in,
  input  logic                en,
  input  logic                mode,
  input  logic [OFFSET_W-1:0] offset,
  output logic [ADC_W-1:0]    j_pos,
  output logic [ADC_W-1:0]    j_neg,
  output logic [ADC_W:0]      dj,
  output logic                valid,
  output logic                busy,
  output logic                overrun
);

  localparam int ACC_W = ADC_W + LOG2_N;
  localparam int CNT_W = (OFFSET_W > LOG2_N) ? OFFSET_W : LOG2_N;
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'((1 << LOG2_N) - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_ACCUM = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic             trig_s1, trig_s2, trig_s3;
  logic [2:0]       warm;
  logic             hist_ok, rise_det, fall_det, edge_det, start;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic             pol_q;
  logic             mode_q;
  logic             pair;
  logic             post_vld;
  logic             post_dj;
  logic [ADC_W-1:0] mean;
  logic [ADC_W:0]   diff;

  // Two synchronizer flops plus one history flop.
  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_s1 <= 1'b0;
      trig_s2 <= 1'b0;
      trig_s3 <= 1'b0;
      warm    <= '0;
    end else begin
      trig_s1 <= trig_in;
      trig_s2 <= trig_s1;
      trig_s3 <= trig_s2;
      warm    <= {warm[1:0], 1'b1};
    end
  end

  // Edges are only trusted once the history flop holds a real synchronized
  // sample; otherwise a trigger held high through reset looks like a rise.
  assign hist_ok  = warm[2];
  assign rise_det = hist_ok & trig_s2 & ~trig_s3;
  assign fall_det = hist_ok & ~trig_s2 & trig_s3;
  assign edge_det = rise_det | (mode & fall_det);
  assign start    = en & edge_det & (state_q == S_IDLE);

  assign busy = (state_q != S_IDLE);
  assign mean = acc[ACC_W-1:LOG2_N];
  assign diff = {1'b0, j_pos} - {1'b0, j_neg};

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (offset == '0) ? S_ACCUM : S_DELAY;
      S_DELAY: if (cnt == '0) state_d = S_ACCUM;
      S_ACCUM: if (cnt == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (!en) state_d = S_IDLE;
  end

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      pol_q    <= 1'b0;
      mode_q   <= 1'b0;
      pair     <= 1'b0;
      post_vld <= 1'b0;
      post_dj  <= 1'b0;
      j_pos    <= '0;
      j_neg    <= '0;
      dj       <= '0;
      valid    <= 1'b0;
      overrun  <= 1'b0;
    end else if (!en) begin
      cnt      <= '0;
      acc      <= '0;
      pair     <= 1'b0;
      post_vld <= 1'b0;
      post_dj  <= 1'b0;
      valid    <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      valid    <= 1'b0;
      post_vld <= 1'b0;
      post_dj  <= 1'b0;

      if (busy && edge_det) overrun <= 1'b1;

      // Result stage one cycle after DONE: J registers are already current.
      if (post_vld) begin
        valid <= 1'b1;
        pair  <= 1'b0;
        if (post_dj) dj <= diff;
      end

      case (state_q)
        S_IDLE: begin
          if (edge_det) begin
            pol_q  <= rise_det;
            mode_q <= mode;
            acc    <= '0;
            cnt    <= (offset == '0) ? WIN_LAST : CNT_W'(offset) - CNT_W'(1);
          end
        end
        S_DELAY: begin
          if (cnt == '0) cnt <= WIN_LAST;
          else           cnt <= cnt - CNT_W'(1);
        end
        S_ACCUM: begin
          acc <= acc + ACC_W'(adc_in);
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
        S_DONE: begin
          if (pol_q) begin
            j_pos <= mean;
            if (!mode_q) post_vld <= 1'b1;
            else         pair     <= 1'b1;
          end else begin
            j_neg <= mean;
            if (pair) begin
              post_vld <= 1'b1;
              post_dj  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trig_adc_averager.sv
module tb_trig_adc_averager;

  localparam int N = 16;

  logic        adc_clk = 1'b0;
  logic        rst_n;
  logic        trig_in;
  logic [11:0] adc_in;
  logic        en;
  logic        mode;
  logic [15:0] offset;
  logic [11:0] j_pos, j_neg;
  logic [12:0] dj;
  logic        valid, busy, overrun;

  int nvec  = 0;
  int nfail = 0;

  // Reference model state
  logic [11:0] jp_m   = '0;
  logic [11:0] jn_m   = '0;
  logic [12:0] dj_m   = '0;
  bit          pair_m = 1'b0;

  always #5 adc_clk = ~adc_clk;

  trig_adc_averager dut (
    .adc_clk (adc_clk),
    .rst_n   (rst_n),
    .trig_in (trig_in),
    .adc_in  (adc_in),
    .en      (en),
    .mode    (mode),
    .offset  (offset),
    .j_pos   (j_pos),
    .j_neg   (j_neg),
    .dj      (dj),
    .valid   (valid),
    .busy    (busy),
    .overrun (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] samp(input int pat, input logic [11:0] cval, input int k);
    case (pat)
      1:       return cval;
      2:       return (k % 2 == 1) ? 12'h001 : 12'h002;
      default: return 12'($urandom);
    endcase
  endfunction

  task automatic chk_results(input string tag);
    chk({tag, "_jpos"}, 32'(j_pos), 32'(jp_m));
    chk({tag, "_jneg"}, 32'(j_neg), 32'(jn_m));
    chk({tag, "_dj"},   32'(dj),    32'(dj_m));
  endtask

  // One measurement: trigger edge applied before posedge 1, so edge D is
  // posedge 3. Window is posedges D+off+1..D+off+N, VALID at D+off+N+2.
  task automatic run_meas(input bit rise_e, input bit md, input int off, input int pat,
                          input logic [11:0] cval, input bit scramble, input int extra);
    int          k_last;
    int          sum;
    bit          exp_v;
    logic [11:0] s;
    logic [11:0] mn;
    exp_v  = rise_e ? !md : pair_m;
    k_last = 3 + off + N + 3 + extra;
    sum    = 0;
    @(negedge adc_clk);
    mode    = md;
    offset  = 16'(off);
    trig_in = rise_e;
    for (int k = 1; k <= k_last; k++) begin
      s = samp(pat, cval, k);
      adc_in = s;
      @(posedge adc_clk);
      if (k >= 4 + off && k <= 3 + off + N) sum += int'(s);
      @(negedge adc_clk);
      chk("valid", 32'(valid), 32'(exp_v && (k == 5 + off + N)));
      chk("busy",  32'(busy),  32'(k >= 3 && k <= 3 + off + N));
      if (scramble && k == 4) begin
        offset = 16'($urandom_range(0, 300));
        mode   = !md;
      end
    end
    mn = 12'(sum / N);
    if (rise_e) begin
      jp_m   = mn;
      pair_m = md;
    end else begin
      jn_m = mn;
      if (pair_m) begin
        dj_m   = {1'b0, jp_m} - {1'b0, jn_m};
        pair_m = 1'b0;
      end
    end
    chk_results("meas");
    chk("meas_overrun", 32'(overrun), 32'd0);
  endtask

  // Drop the trigger while in rising-only mode so the fall starts nothing.
  task automatic lower_trig();
    @(negedge adc_clk);
    mode    = 1'b0;
    trig_in = 1'b0;
    repeat (6) @(negedge adc_clk);
    chk("quiet_busy", 32'(busy), 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge adc_clk);
    rst_n = 1'b0;
    #1;
    chk("rst_jpos",    32'(j_pos),   32'd0);
    chk("rst_jneg",    32'(j_neg),   32'd0);
    chk("rst_dj",      32'(dj),      32'd0);
    chk("rst_valid",   32'(valid),   32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    jp_m = '0; jn_m = '0; dj_m = '0; pair_m = 1'b0;
    repeat (2) @(negedge adc_clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge adc_clk);
      chk("post_rst_busy",  32'(busy),  32'd0);
      chk("post_rst_valid", 32'(valid), 32'd0);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    trig_in = 1'b0;
    en      = 1'b1;
    mode    = 1'b0;
    offset  = '0;
    adc_in  = '0;
    repeat (2) @(negedge adc_clk);
    chk("init_jpos",    32'(j_pos),   32'd0);
    chk("init_jneg",    32'(j_neg),   32'd0);
    chk("init_dj",      32'(dj),      32'd0);
    chk("init_valid",   32'(valid),   32'd0);
    chk("init_busy",    32'(busy),    32'd0);
    chk("init_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge adc_clk);

    // Single-edge, constant input
    run_meas(1'b1, 1'b0, 4, 1, 12'h523, 1'b0, 0);
    lower_trig();
    // Truncation with OFFSET=0
    run_meas(1'b1, 1'b0, 0, 2, 12'h000, 1'b0, 0);
    lower_trig();
    // Full scale, with MODE/OFFSET disturbed mid-measurement
    run_meas(1'b1, 1'b0, 9, 1, 12'hFFF, 1'b1, 0);
    lower_trig();

    // Differential, full period: DJ = +3 then -3
    run_meas(1'b1, 1'b1, 150, 1, 12'h523, 1'b0, 300);
    run_meas(1'b0, 1'b1, 150, 1, 12'h520, 1'b0, 300);
    run_meas(1'b1, 1'b1, 150, 1, 12'h520, 1'b0, 300);
    run_meas(1'b0, 1'b1, 150, 1, 12'h523, 1'b0, 300);

    // Randomized measurements
    for (int i = 0; i < 8; i++) begin
      int off;
      off = $urandom_range(0, 40);
      if ($urandom_range(0, 1) == 1) begin
        run_meas(1'b1, 1'b1, off, 0, 12'h000, 1'($urandom_range(0, 1)), 0);
        run_meas(1'b0, 1'b1, $urandom_range(0, 40), 0, 12'h000, 1'($urandom_range(0, 1)), 0);
      end else begin
        run_meas(1'b1, 1'b0, off, 0, 12'h000, 1'($urandom_range(0, 1)), 0);
        lower_trig();
      end
    end

    // Overrun: edges every 100 cycles against a 216-cycle measurement
    lower_trig();
    @(negedge adc_clk);
    mode    = 1'b1;
    offset  = 16'd200;
    adc_in  = 12'h3A7;
    trig_in = 1'b1;
    for (int k = 1; k <= 240; k++) begin
      @(negedge adc_clk);
      chk("ovr_valid", 32'(valid), 32'd0);
      if (k == 100) trig_in = 1'b0;
      if (k == 200) trig_in = 1'b1;
    end
    jp_m   = 12'h3A7;
    pair_m = 1'b1;
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_busy", 32'(busy),    32'd0);
    chk_results("ovr");
    @(negedge adc_clk);
    en = 1'b0;
    @(negedge adc_clk);
    chk("en_clr_overrun", 32'(overrun), 32'd0);
    en     = 1'b1;
    pair_m = 1'b0;
    // Pair cleared by EN: this fall must not produce VALID
    run_meas(1'b0, 1'b1, 10, 0, 12'h000, 1'b0, 0);

    // EN abort during ACCUM
    @(negedge adc_clk);
    mode    = 1'b0;
    offset  = 16'd10;
    trig_in = 1'b1;
    adc_in  = 12'h7FF;
    repeat (20) @(negedge adc_clk);
    chk("abort_busy_pre", 32'(busy), 32'd1);
    en = 1'b0;
    @(negedge adc_clk);
    chk("abort_busy", 32'(busy), 32'd0);
    en = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge adc_clk);
      chk("abort_valid", 32'(valid), 32'd0);
    end
    chk_results("abort");

    // Reset during ACCUM, trigger held high through release
    lower_trig();
    @(negedge adc_clk);
    mode    = 1'b0;
    offset  = 16'd4;
    trig_in = 1'b1;
    repeat (12) @(negedge adc_clk);
    pulse_reset();
    lower_trig();
    run_meas(1'b1, 1'b0, 4, 0, 12'h000, 1'b0, 0);

    // Fall first after reset in differential mode
    pulse_reset();
    run_meas(1'b0, 1'b1, 7, 0, 12'h000, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/trig_adc_averager.md
TRIG_ADC_AVERAGER -- requirements
Module: trig_adc_averager

Interface
REQ-001 Parameter ADC_W, default 12, ADC sample width in bits (unsigned offset-binary).
REQ-002 Parameter LOG2_N, default 4, log2 of window length; N = 2^LOG2_N samples per measurement.
REQ-003 Parameter OFFSET_W, default 16, width of the post-trigger delay count.
REQ-004 ADC_CLK  input  1  sole clock; all logic on the rising edge.
REQ-005 RST_N  input  1  reset, asynchronous and active-low.
REQ-006 TRIG_IN  input  1  asynchronous trigger (~20 kHz square wave); high phase = +perturbation, low phase = -perturbation.
REQ-007 ADC_IN  input  ADC_W  ADC sample, synchronous to ADC_CLK.
REQ-008 EN  input  1  enable; low forces IDLE and clears OVERRUN.
REQ-009 MODE  input  1  0 = single-edge (rising only); 1 = differential (rising and falling).
REQ-010 OFFSET  input  OFFSET_W  settling delay in ADC_CLK cycles between trigger detection and first sample.
REQ-011 J_POS  output  ADC_W  window mean of the last rising-edge measurement.
REQ-012 J_NEG  output  ADC_W  window mean of the last falling-edge measurement.
REQ-013 DJ  output  ADC_W+1  signed two's-complement J_POS - J_NEG.
REQ-014 VALID  output  1  one-cycle result strobe.
REQ-015 BUSY  output  1  high in any state other than IDLE.
REQ-016 OVERRUN  output  1  sticky flag: a trigger edge arrived while BUSY.

Function
REQ-017 TRIG_IN shall pass through a 2-flop synchronizer plus one history flop; a rise or fall is detected from the last two stages.
REQ-018 The FSM shall have states IDLE, DELAY, ACCUM and DONE.
REQ-019 IDLE -> DELAY on a detected rising edge, or on a falling edge when MODE=1, with EN=1; the edge polarity shall be latched. The clock edge of this transition is edge D, the third ADC_CLK edge after TRIG_IN changes with setup met.
REQ-020 DELAY shall last exactly OFFSET cycles; OFFSET=0 shall go directly to ACCUM.
REQ-021 ACCUM shall sum exactly N consecutive ADC_IN samples, taken on edges D+OFFSET+1 through D+OFFSET+N, into a zero-extended accumulator of ADC_W+LOG2_N bits with no overflow.
REQ-022 DONE shall last one cycle and store sum >> LOG2_N (truncating) into J_POS or J_NEG, according to the latched polarity, then return to IDLE.
REQ-023 MODE=0: VALID shall be asserted in the cycle after each DONE; DJ shall be held.
REQ-024 MODE=1: after a falling measurement, DJ shall be updated and VALID asserted in the following cycle only if a rising measurement has completed since the last VALID (pair flag); the pair flag shall be cleared on VALID.
REQ-025 VALID latency in every case shall be edge D+OFFSET+N+2, asserted for one cycle.
REQ-026 A detected edge while BUSY shall be ignored and shall set OVERRUN; the measurement in progress shall continue unaffected.
REQ-027 EN low shall abort any measurement to IDLE on the next edge, clear OVERRUN and the pair flag, and leave J_POS, J_NEG and DJ unchanged.
REQ-028 OFFSET and MODE shall be sampled at edge D; changes during a measurement shall have no effect until the next trigger.
REQ-029 A trigger edge coinciding with DONE shall count as BUSY (REQ-026).

Reset
REQ-030 RST_N low shall asynchronously clear the state to IDLE; clear the synchronizer flops, accumulator, counters and pair flag; and drive J_POS, J_NEG, DJ, VALID, BUSY and OVERRUN to 0.
REQ-031 Reset asserted mid-measurement shall discard the measurement with no VALID; the first edge-history sample after release shall not generate a spurious edge.

Verification
REQ-032 Defaults, MODE=0, OFFSET=4, ADC_IN=0x523 constant, one TRIG_IN rise -> single VALID at D+22, J_POS=0x523, J_NEG=0, DJ=0.
REQ-033 MODE=1, OFFSET=150, ADC_IN=0x523 during the high phase and 0x520 during the low phase, full 20 kHz period -> VALID once per period after the fall, J_POS=0x523, J_NEG=0x520, DJ=+3. Swapped values -> DJ=0x1FFD (-3).
REQ-034 ADC_IN alternating 0x001/0x002 per cycle, N=16 -> sum 24, J_POS=0x001 (truncation). ADC_IN=0xFFF constant -> J_POS=0xFFF (no overflow).
REQ-035 MODE=1, OFFSET=200, trigger half-period of 100 cycles -> falls ignored, OVERRUN=1, no VALID. EN pulsed low then high -> OVERRUN=0.
REQ-036 RST_N low for 2 cycles during ACCUM -> all outputs 0 immediately, no VALID. The next clean trigger gives a normal result. MODE=1 with a fall first after reset -> J_NEG updated, no VALID.
